// File: rtl/pe_act_pipe.sv
// rtl/pe_act_pipe.sv - multi-lane activation + requantise pipeline with saturation counter
module pe_act_pipe #(
    parameter int W_IN  = 24,
    parameter int W_OUT = 8,
    parameter int LANES = 4,
    parameter int SH_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               cfg_mode,
    input  logic [SH_W-1:0]          cfg_shift,
    input  logic [SH_W-1:0]          cfg_leak_shift,
    input  logic [W_IN-1:0]          cfg_clip,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*W_IN-1:0]    in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*W_OUT-1:0]   out_data,
    output logic [LANES-1:0]         out_sat,
    output logic [CNT_W-1:0]         sat_cnt,
    input  logic                     sat_clr
);

    localparam logic signed [W_IN:0] QMAX = {{(W_IN-W_OUT+2){1'b0}}, {(W_OUT-1){1'b1}}};
    localparam logic signed [W_IN:0] QMIN = {{(W_IN-W_OUT+2){1'b1}}, {(W_OUT-1){1'b0}}};

    logic                   s1_valid;
    logic [LANES*W_IN-1:0]  s1_data;
    logic [SH_W-1:0]        s1_shift;
    logic                   s2_valid;
    logic                   s1_adv;
    logic                   s2_adv;

    logic [LANES*W_IN-1:0]  act_flat;
    logic [LANES*W_OUT-1:0] q_flat;
    logic [LANES-1:0]       sat_flat;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [W_IN-1:0] x;
        logic signed [W_IN-1:0] a;
        logic signed [W_IN-1:0] sa;
        logic signed [W_IN:0]   ae;
        logic        [W_IN:0]   rnd;
        logic signed [W_IN:0]   sum;
        logic signed [W_IN:0]   r;

        assign x = in_data[g*W_IN +: W_IN];

        // Clip ceiling is compared unsigned: only reached once x is known non-negative.
        always_comb begin
            a = x;
            case (cfg_mode)
                2'd1: a = x[W_IN-1] ? '0 : x;
                2'd2: a = x[W_IN-1] ? (x >>> cfg_leak_shift) : x;
                2'd3: begin
                    if (x[W_IN-1])
                        a = '0;
                    else if ($unsigned(x) > cfg_clip)
                        a = cfg_clip;
                    else
                        a = x;
                end
                default: a = x;
            endcase
        end
        assign act_flat[g*W_IN +: W_IN] = a;

        // One guard bit keeps the rounding add from wrapping at the positive maximum.
        assign sa  = s1_data[g*W_IN +: W_IN];
        assign ae  = {sa[W_IN-1], sa};
        assign rnd = (s1_shift != '0) ? ({{W_IN{1'b0}}, 1'b1} << (s1_shift - 1'b1)) : '0;
        assign sum = ae + $signed(rnd);
        assign r   = sum >>> s1_shift;

        always_comb begin
            q_flat[g*W_OUT +: W_OUT] = r[W_OUT-1:0];
            sat_flat[g]              = 1'b0;
            if (r > QMAX) begin
                q_flat[g*W_OUT +: W_OUT] = QMAX[W_OUT-1:0];
                sat_flat[g]              = 1'b1;
            end else if (r < QMIN) begin
                q_flat[g*W_OUT +: W_OUT] = QMIN[W_OUT-1:0];
                sat_flat[g]              = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_shift <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data  <= act_flat;
                s1_shift <= cfg_shift;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            out_data <= '0;
            out_sat  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= q_flat;
                out_sat  <= sat_flat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || sat_clr)
            sat_cnt <= '0;
        else if (out_valid && out_ready && (|out_sat) && (sat_cnt != {CNT_W{1'b1}}))
            sat_cnt <= sat_cnt + 1'b1;
    end

endmodule

// File: tb/tb_pe_act_pipe.sv
// tb/tb_pe_act_pipe.sv - directed self-checking bench for pe_act_pipe
module tb_pe_act_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cfg_mode;
    logic [4:0]  cfg_shift;
    logic [4:0]  cfg_leak_shift;
    logic [23:0] cfg_clip;
    logic        in_valid;
    logic        in_ready;
    logic [95:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_sat;
    logic [15:0] sat_cnt;
    logic        sat_clr;

    int total = 0;
    int bad = 0;

    pe_act_pipe #(.W_IN(24), .W_OUT(8), .LANES(4), .SH_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .cfg_mode(cfg_mode), .cfg_shift(cfg_shift),
        .cfg_leak_shift(cfg_leak_shift), .cfg_clip(cfg_clip),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat),
        .sat_cnt(sat_cnt), .sat_clr(sat_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [95:0] pin(int a, int b, int c, int d);
        return {d[23:0], c[23:0], b[23:0], a[23:0]};
    endfunction

    function automatic logic [31:0] pout(int a, int b, int c, int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int mode, input int sh, input int leak, input int clip);
        cfg_mode       = mode[1:0];
        cfg_shift      = sh[4:0];
        cfg_leak_shift = leak[4:0];
        cfg_clip       = clip[23:0];
    endtask

    // One beat with out_ready high: accept, then output exactly two edges later.
    task automatic send_check(input string tag, input logic [95:0] d,
                              input logic [31:0] exp_d, input logic [3:0] exp_s);
        in_data   = d;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        chk({tag, "_in_ready"}, in_ready, 1);
        step();
        in_valid = 1'b0;
        chk({tag, "_lat1_valid"}, out_valid, 0);
        step();
        chk({tag, "_lat2_valid"}, out_valid, 1);
        chk({tag, "_data"}, out_data, exp_d);
        chk({tag, "_sat"}, out_sat, exp_s);
        step();
    endtask

    int          sent;
    int          recv;
    logic        prev_stall;
    logic [31:0] prev_data;

    initial begin
        rst = 1'b1; sat_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0;
        set_cfg(0, 0, 0, 0);
        step(); step();
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_sat_cnt", sat_cnt, 0);
        chk("rst_in_ready", in_ready, 1);

        set_cfg(1, 0, 0, 0);
        send_check("relu", pin(0, 7, -1, -123456), pout(0, 7, 0, 0), 4'b0000);
        chk("relu_sat_cnt", sat_cnt, 0);

        set_cfg(2, 0, 2, 0);
        send_check("leaky", pin(-8, -1, 100, 300), pout(-2, -1, 100, 127), 4'b1000);
        chk("leaky_sat_cnt", sat_cnt, 1);

        set_cfg(3, 1, 0, 50);
        send_check("clip", pin(-5, 49, 51, 1000), pout(0, 25, 25, 25), 4'b0000);
        chk("clip_sat_cnt", sat_cnt, 1);

        set_cfg(0, 4, 0, 0);
        send_check("bypass_sh4", pin(24, 23, -24, -8388608), pout(2, 1, -1, -128), 4'b1000);
        chk("bypass_sat_cnt", sat_cnt, 2);

        // Config travels with each beat: back-to-back beats with different modes.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = pin(-5, 5, -200, 3);
        set_cfg(1, 0, 0, 0);
        step();
        set_cfg(0, 0, 0, 0);
        step();
        in_valid = 1'b0;
        chk("cfg_a_valid", out_valid, 1);
        chk("cfg_a_data", out_data, pout(0, 5, 0, 3));
        step();
        chk("cfg_b_valid", out_valid, 1);
        chk("cfg_b_data", out_data, pout(-5, 5, -128, 3));
        chk("cfg_b_sat", out_sat, 4'b0100);
        step();
        chk("cfg_sat_cnt", sat_cnt, 3);

        // Backpressure stream, out_ready pattern 1,0,0,1.
        set_cfg(0, 0, 0, 0);
        sent = 0; recv = 0; prev_stall = 1'b0; prev_data = '0;
        for (int cyc = 0; cyc < 100 && recv < 8; cyc++) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            in_valid  = (sent < 8);
            in_data   = pin(sent*4, sent*4+1, sent*4+2, sent*4+3);
            #1;
            if (prev_stall) begin
                chk("bp_hold_valid", out_valid, 1);
                chk("bp_hold_data", out_data, prev_data);
            end
            if ((sent - recv == 2) && !out_ready)
                chk("bp_full_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                chk("bp_data", out_data, pout(recv*4, recv*4+1, recv*4+2, recv*4+3));
                recv++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (in_valid && in_ready)
                sent++;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_recv_count", recv, 8);
        step(); step();
        chk("bp_no_extra", out_valid, 0);

        // Reset with two beats in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = pin(300, 1, 2, 3);
        step(); step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_out_valid", out_valid, 0);
        chk("rst2_sat_cnt", sat_cnt, 0);
        chk("rst2_in_ready", in_ready, 1);
        chk("rst2_out_data", out_data, 0);
        out_ready = 1'b1;
        step(); step();
        chk("rst2_flushed", out_valid, 0);

        // Drive the counter to its ceiling and beyond.
        in_valid = 1'b1;
        in_data  = pin(300, 0, 0, 0);
        for (int i = 0; i < 65535 + 5; i++) step();
        in_valid = 1'b0;
        step(); step(); step();
        chk("cnt_hold_max", sat_cnt, 16'hffff);

        // Clear coinciding with a saturating handshake.
        send_check("clr_beat_pre", pin(-300, 0, 0, 0), pout(-128, 0, 0, 0), 4'b0001);
        chk("cnt_still_max", sat_cnt, 16'hffff);
        in_data  = pin(0, 0, 0, 1000);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("clr_valid", out_valid, 1);
        chk("clr_sat", out_sat, 4'b1000);
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        chk("clr_wins", sat_cnt, 0);

        send_check("post_clr", pin(0, 0, 500, 0), pout(0, 0, 127, 0), 4'b0100);
        chk("post_clr_cnt", sat_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
